uart_cmd_master: RTL and testbench
==================================

# uart_cmd_master

Byte-stream command engine that sits directly behind the UART AXI bridge. It pulls received bytes from the bridge's read channel and parses fixed-length read/write frames. It executes each frame as a single AXI4-Lite transaction on the host bus, then returns the reply bytes through the bridge's write channel. It is the debug/bring-up path from a PC serial port into the memory-mapped register space.

## Interface
Parameters:
- TIMEOUT_CLKS, 32'd1_000_000: maximum idle clocks between bytes of one frame before the frame is dropped.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- u_araddr  out  32  bridge read address; constant 0
- u_arvalid / u_arready  out / in  1  bridge read-address handshake
- u_rdata  in  32  received byte in [7:0]
- u_rvalid / u_rready  in / out  1  bridge read-data handshake
- u_awaddr  out  32  bridge write address; constant 0
- u_awvalid / u_awready  out / in  1  bridge write-address handshake
- u_wdata  out  32  reply byte in [7:0]; [31:8] = 0
- u_wvalid / u_wready  out / in  1  bridge write-data handshake
- u_bvalid / u_bready  in / out  1  bridge write-response handshake; u_bresp ignored
- m_awaddr, m_wdata, m_araddr  out  32  host-bus address/data
- m_wstrb  out  4  constant 4'hF
- m_awvalid/m_awready, m_wvalid/m_wready, m_arvalid/m_arready  out/in  1  host-bus request handshakes
- m_bvalid/m_bready, m_rvalid/m_rready  in/out  1  host-bus response handshakes
- m_bresp, m_rresp  in  2  response codes; nonzero = error
- m_rdata  in  32  host-bus read data
- busy  out  1  high in every state except CMD

## Operation
- Frames, multi-byte fields MSB first:
  - Write: 0x57 'W', A3..A0, D3..D0.
  - Read: 0x52 'R', A3..A0.
- Replies:
  - Write: 0x4B 'K' if m_bresp==0, else 0x45 'E'.
  - Read: 4 bytes of m_rdata MSB first if m_rresp==0, else single 0x45.
  - Any other command byte: single 0x3F '?'. It is consumed; parsing restarts at the next byte.
- Byte fetch sub-sequence:
  - Drive u_arvalid until u_arready; then drive u_rready=1 until u_rvalid.
  - Capture u_rdata[7:0] on the u_rvalid cycle.
  - u_rready never depends combinationally on u_rvalid.
- Main states: CMD, ADDR (4 bytes), DATA (4 bytes, write only), M_WR, M_WR_B, M_RD, M_RD_R, TX, TX_B.
- Counters:
  - 2-bit byte counter shifts bytes into the 32-bit addr/data registers; it wraps 3->0 at field end.
  - 2-bit reply index selects byte 3,2,1,0 of the reply register.
- M_WR:
  - Assert m_awvalid and m_wvalid together.
  - Drop each independently on its own handshake, including simultaneous handshakes in one cycle.
  - Move to M_WR_B once both have completed; m_bready=1 there.
- M_RD: m_arvalid until m_arready; then M_RD_R with m_rready=1; capture m_rdata/m_rresp.
- TX:
  - Assert u_awvalid and u_wvalid together with the reply byte; both are held stable until their handshakes complete.
  - TX_B: u_bready=1 until u_bvalid.
  - Then next reply byte, or CMD after the last.
- Timeout:
  - Counter cleared on every captured byte; it runs only in ADDR/DATA.
  - Reaching TIMEOUT_CLKS-1 drops the partial frame and returns to CMD with no reply.
  - Any AR already issued completes normally; the fetched byte is discarded.
- No timeout on either bus; a stalled slave stalls the block.
- rst mid-operation: return to CMD immediately; all valids drop the same cycle. Host-bus transactions in flight are abandoned.

## Timing
- Reset values: all valid/ready outputs 0, all address/data outputs 0, m_wstrb 4'hF, busy 0.
- One byte fetch takes at least 2 cycles: AR accepted in cycle n, byte captured no earlier than cycle n+1.
- m_awvalid/m_wvalid rise 1 cycle after the last data byte is captured. m_arvalid rises 1 cycle after A0 is captured.
- u_wvalid rises 1 cycle after m_bvalid&m_bready or m_rvalid&m_rready.
- Next reply byte is offered 1 cycle after u_bvalid&u_bready.
- After the final reply handshake, the block is in CMD and asserts u_arvalid the following cycle.

## Test plan
- Write frame 57 00 00 10 04 DE AD BE EF, slave bresp=0:
  - m_awaddr=0x00001004, m_wdata=0xDEADBEEF, m_wstrb=F.
  - Reply byte 0x4B.
- Read frame 52 00 00 10 04, slave returns 0x12345678 rresp=0: reply bytes 12,34,56,78 in order.
- Error responses: write with bresp=2'b10 -> reply 0x45; read with rresp=2'b11 -> single reply 0x45.
- Byte 0x41 then valid read frame: reply 0x3F, then the read executes normally.
- Partial frame 57 00 00, then no bytes for TIMEOUT_CLKS (set to 100): back in CMD with no bus activity; busy=0. Next full frame works.
- Two bus scenarios:
  - m_awready and m_wready in different cycles, and both in the same cycle: exactly one write each.
  - rst asserted during TX: all valids 0 next cycle; busy=0.

Source files
------------

// File: rtl/uart_cmd_master.sv
// uart_cmd_master: parses 'W'/'R' byte frames from the UART bridge, runs one AXI4-Lite
// transaction per frame on the host bus and streams the reply bytes back to the bridge.
module uart_cmd_master #(
    parameter logic [31:0] TIMEOUT_CLKS = 32'd1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] u_araddr,
    output logic        u_arvalid,
    input  logic        u_arready,
    input  logic [31:0] u_rdata,
    input  logic        u_rvalid,
    output logic        u_rready,
    output logic [31:0] u_awaddr,
    output logic        u_awvalid,
    input  logic        u_awready,
    output logic [31:0] u_wdata,
    output logic        u_wvalid,
    input  logic        u_wready,
    input  logic        u_bvalid,
    output logic        u_bready,
    output logic [31:0] m_awaddr,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic        m_bvalid,
    output logic        m_bready,
    input  logic [1:0]  m_bresp,
    output logic [31:0] m_araddr,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic        m_rvalid,
    output logic        m_rready,
    input  logic [1:0]  m_rresp,
    input  logic [31:0] m_rdata,
    output logic        busy
);
    typedef enum logic [3:0] {CMD, ADDR, DATA, M_WR, M_WR_B, M_RD, M_RD_R, TX, TX_B} state_t;
    state_t      r_state;
    logic [1:0]  r_cnt, r_ridx;
    logic [31:0] r_addr, r_data, r_reply, r_tmo;
    logic        r_wr, r_drop;
    logic        r_u_arvalid, r_u_rready, r_u_awvalid, r_u_wvalid, r_u_bready;
    logic        r_m_awvalid, r_m_wvalid, r_m_bready, r_m_arvalid, r_m_rready;
    logic        w_fetch, w_cap, w_unused;
    logic [7:0]  w_byte, w_tx_byte;
    assign w_fetch   = r_state == CMD || r_state == ADDR || r_state == DATA;
    assign w_cap     = r_u_rready && u_rvalid;
    assign w_byte    = u_rdata[7:0];
    assign w_tx_byte = r_reply[{r_ridx, 3'b000} +: 8];
    assign w_unused  = ^u_rdata[31:8];
    assign u_araddr  = '0;
    assign u_awaddr  = '0;
    assign u_wdata   = {24'd0, w_tx_byte};
    assign m_wstrb   = 4'hF;
    assign m_awaddr  = r_addr;
    assign m_araddr  = r_addr;
    assign m_wdata   = r_data;
    assign busy      = r_state != CMD;
    assign u_arvalid = r_u_arvalid;
    assign u_rready  = r_u_rready;
    assign u_awvalid = r_u_awvalid;
    assign u_wvalid  = r_u_wvalid;
    assign u_bready  = r_u_bready;
    assign m_awvalid = r_m_awvalid;
    assign m_wvalid  = r_m_wvalid;
    assign m_bready  = r_m_bready;
    assign m_arvalid = r_m_arvalid;
    assign m_rready  = r_m_rready;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= CMD;
            r_cnt       <= '0;
            r_ridx      <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_reply     <= '0;
            r_tmo       <= '0;
            r_wr        <= 1'b0;
            r_drop      <= 1'b0;
            r_u_arvalid <= 1'b0;
            r_u_rready  <= 1'b0;
            r_u_awvalid <= 1'b0;
            r_u_wvalid  <= 1'b0;
            r_u_bready  <= 1'b0;
            r_m_awvalid <= 1'b0;
            r_m_wvalid  <= 1'b0;
            r_m_bready  <= 1'b0;
            r_m_arvalid <= 1'b0;
            r_m_rready  <= 1'b0;
        end else begin
            if (w_fetch && !r_u_arvalid && !r_u_rready)
                r_u_arvalid <= 1'b1;
            if (r_u_arvalid && u_arready) begin
                r_u_arvalid <= 1'b0;
                r_u_rready  <= 1'b1;
            end
            if (w_cap) begin
                r_u_rready <= 1'b0;
                r_tmo      <= '0;
            end
            // a byte whose fetch outlived a timed-out frame is thrown away
            if (w_cap && r_drop) begin
                r_drop <= 1'b0;
            end else if (w_cap) begin
                case (r_state)
                    CMD: begin
                        r_wr  <= w_byte == 8'h57;
                        r_cnt <= '0;
                        if (w_byte == 8'h57 || w_byte == 8'h52) begin
                            r_state <= ADDR;
                        end else begin
                            r_reply     <= 32'h3F;
                            r_ridx      <= '0;
                            r_u_awvalid <= 1'b1;
                            r_u_wvalid  <= 1'b1;
                            r_state     <= TX;
                        end
                    end
                    ADDR: begin
                        r_addr <= {r_addr[23:0], w_byte};
                        r_cnt  <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_state     <= r_wr ? DATA : M_RD;
                            r_m_arvalid <= !r_wr;
                        end
                    end
                    DATA: begin
                        r_data <= {r_data[23:0], w_byte};
                        r_cnt  <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_m_awvalid <= 1'b1;
                            r_m_wvalid  <= 1'b1;
                            r_state     <= M_WR;
                        end
                    end
                    default: ;
                endcase
            end else if (r_state == ADDR || r_state == DATA) begin
                if (r_tmo == TIMEOUT_CLKS - 32'd1) begin
                    r_tmo   <= '0;
                    r_drop  <= r_u_arvalid || r_u_rready;
                    r_state <= CMD;
                end else begin
                    r_tmo <= r_tmo + 32'd1;
                end
            end
            case (r_state)
                M_WR: begin
                    if (m_awready) r_m_awvalid <= 1'b0;
                    if (m_wready) r_m_wvalid <= 1'b0;
                    if ((!r_m_awvalid || m_awready) && (!r_m_wvalid || m_wready)) begin
                        r_m_bready <= 1'b1;
                        r_state    <= M_WR_B;
                    end
                end
                M_WR_B: if (m_bvalid) begin
                    r_m_bready  <= 1'b0;
                    r_reply     <= m_bresp == 2'b00 ? 32'h4B : 32'h45;
                    r_ridx      <= '0;
                    r_u_awvalid <= 1'b1;
                    r_u_wvalid  <= 1'b1;
                    r_state     <= TX;
                end
                M_RD: if (m_arready) begin
                    r_m_arvalid <= 1'b0;
                    r_m_rready  <= 1'b1;
                    r_state     <= M_RD_R;
                end
                M_RD_R: if (m_rvalid) begin
                    r_m_rready  <= 1'b0;
                    r_reply     <= m_rresp == 2'b00 ? m_rdata : 32'h45;
                    r_ridx      <= m_rresp == 2'b00 ? 2'd3 : 2'd0;
                    r_u_awvalid <= 1'b1;
                    r_u_wvalid  <= 1'b1;
                    r_state     <= TX;
                end
                TX: begin
                    if (u_awready) r_u_awvalid <= 1'b0;
                    if (u_wready) r_u_wvalid <= 1'b0;
                    if ((!r_u_awvalid || u_awready) && (!r_u_wvalid || u_wready)) begin
                        r_u_bready <= 1'b1;
                        r_state    <= TX_B;
                    end
                end
                TX_B: if (u_bvalid) begin
                    r_u_bready <= 1'b0;
                    if (r_ridx == 2'd0) begin
                        r_u_arvalid <= 1'b1;
                        r_state     <= CMD;
                    end else begin
                        r_ridx      <= r_ridx - 2'd1;
                        r_u_awvalid <= 1'b1;
                        r_u_wvalid  <= 1'b1;
                        r_state     <= TX;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cmd_master.sv
// tb_uart_cmd_master: directed frames through a UART bridge model and an AXI4-Lite
// slave model; replies and host-bus captures are compared against hand-computed values.
module tb_uart_cmd_master;
    logic clk = 1'b0, rst;
    always #5 clk = ~clk;
    logic [31:0] u_araddr, u_rdata, u_awaddr, u_wdata, m_awaddr, m_wdata, m_araddr, m_rdata;
    logic        u_arvalid, u_arready, u_rvalid, u_rready, u_awvalid, u_awready;
    logic        u_wvalid, u_wready, u_bvalid, u_bready;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready, busy;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;

    uart_cmd_master #(.TIMEOUT_CLKS(32'd100)) dut (
        .clk(clk), .rst(rst),
        .u_araddr(u_araddr), .u_arvalid(u_arvalid), .u_arready(u_arready),
        .u_rdata(u_rdata), .u_rvalid(u_rvalid), .u_rready(u_rready),
        .u_awaddr(u_awaddr), .u_awvalid(u_awvalid), .u_awready(u_awready),
        .u_wdata(u_wdata), .u_wvalid(u_wvalid), .u_wready(u_wready),
        .u_bvalid(u_bvalid), .u_bready(u_bready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rresp(m_rresp), .m_rdata(m_rdata),
        .busy(busy)
    );

    int n_chk = 0, n_err = 0;
    logic [7:0] rxq[$], txq[$];
    int ar_pend, aw_cnt, w_cnt, aw_dly, w_dly, n_aw, n_w, n_ar;
    logic ugot_aw, ugot_w, h_aw, h_w, h_ar, uw_en;
    logic [1:0] bresp_cfg, rresp_cfg;
    logic [31:0] rdata_cfg, cap_awaddr, cap_wdata, cap_araddr;
    logic [3:0] cap_wstrb;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // bridge and host-slave models: handshakes sampled mid-cycle, responses updated after the edge
    initial begin
        logic s_ar, s_r, s_uaw, s_uw, s_ub, s_maw, s_mw, s_mb, s_mar, s_mr, v_aw, v_w;
        logic [31:0] s_awaddr, s_wdata, s_araddr;
        logic [3:0] s_wstrb;
        logic [7:0] s_byte;
        {ar_pend, aw_cnt, w_cnt, n_aw, n_w, n_ar} = '0;
        {ugot_aw, ugot_w, h_aw, h_w, h_ar} = '0;
        {cap_awaddr, cap_wdata, cap_araddr, cap_wstrb} = '0;
        u_arready = 1; u_rvalid = 0; u_rdata = 0; u_awready = 1; u_wready = 1; u_bvalid = 0;
        m_awready = 1; m_wready = 1; m_bvalid = 0; m_bresp = 0;
        m_arready = 1; m_rvalid = 0; m_rresp = 0; m_rdata = 0;
        forever begin
            @(negedge clk);
            s_ar = u_arvalid && u_arready; s_r = u_rvalid && u_rready;
            s_uaw = u_awvalid && u_awready; s_uw = u_wvalid && u_wready; s_ub = u_bvalid && u_bready;
            s_maw = m_awvalid && m_awready; s_mw = m_wvalid && m_wready; s_mb = m_bvalid && m_bready;
            s_mar = m_arvalid && m_arready; s_mr = m_rvalid && m_rready;
            v_aw = m_awvalid; v_w = m_wvalid; s_byte = u_wdata[7:0];
            s_awaddr = m_awaddr; s_wdata = m_wdata; s_araddr = m_araddr; s_wstrb = m_wstrb;
            @(posedge clk);
            #1;
            if (rst) begin
                {ar_pend, aw_cnt, w_cnt} = '0;
                {ugot_aw, ugot_w, h_aw, h_w, h_ar} = '0;
                {u_rvalid, u_bvalid, m_bvalid, m_rvalid} = '0;
            end else begin
                if (s_ar) ar_pend++;
                if (s_r) begin ar_pend--; void'(rxq.pop_front()); end
                u_rvalid = ar_pend > 0 && rxq.size() > 0;
                u_rdata = u_rvalid ? {24'd0, rxq[0]} : 32'd0;
                if (s_ub) begin ugot_aw = 0; ugot_w = 0; end
                if (s_uaw) ugot_aw = 1;
                if (s_uw) begin ugot_w = 1; txq.push_back(s_byte); end
                u_bvalid = ugot_aw && ugot_w;
                if (s_mb) begin h_aw = 0; h_w = 0; end
                if (s_maw) begin n_aw++; h_aw = 1; aw_cnt = 0; cap_awaddr = s_awaddr; end
                else if (v_aw) aw_cnt++;
                if (s_mw) begin n_w++; h_w = 1; w_cnt = 0; cap_wdata = s_wdata; cap_wstrb = s_wstrb; end
                else if (v_w) w_cnt++;
                m_bvalid = h_aw && h_w; m_bresp = bresp_cfg;
                if (s_mr) h_ar = 0;
                if (s_mar) begin n_ar++; h_ar = 1; cap_araddr = s_araddr; end
                m_rvalid = h_ar; m_rdata = rdata_cfg; m_rresp = rresp_cfg;
            end
            u_wready = uw_en; m_awready = aw_cnt >= aw_dly; m_wready = w_cnt >= w_dly;
        end
    end

    task automatic push(input logic [71:0] v, input int n);
        for (int i = 0; i < n; i++) rxq.push_back(v[8*(n-1-i) +: 8]);
    endtask

    task automatic exp_reply(input string tag, input int n, input logic [39:0] v);
        int t = 0;
        while ((txq.size() < n || busy) && t < 3000) begin @(negedge clk); t++; end
        chk({tag, "_wait"}, t < 3000, 1);
        repeat (4) @(negedge clk);
        chk({tag, "_len"}, txq.size(), n);
        for (int i = 0; i < n && i < txq.size(); i++) chk(tag, txq[i], v[8*(n-1-i) +: 8]);
        txq.delete();
    endtask

    initial begin
        int t, b_aw, b_w, b_ar;
        rst = 1; aw_dly = 0; w_dly = 0; uw_en = 1; bresp_cfg = 0; rresp_cfg = 0; rdata_cfg = 0;
        repeat (3) @(negedge clk);
        chk("rst_valids", {u_arvalid, u_rready, u_awvalid, u_wvalid, u_bready,
                           m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);
        chk("rst_addr", u_araddr | u_awaddr | u_wdata | m_awaddr | m_araddr | m_wdata, 0);
        chk("rst_wstrb", m_wstrb, 4'hF);
        chk("rst_busy", busy, 0);
        rst = 0;

        push(72'h57_00001004_DEADBEEF, 9);
        exp_reply("wr_ok", 1, 40'h4B);
        chk("wr_awaddr", cap_awaddr, 32'h00001004);
        chk("wr_wdata", cap_wdata, 32'hDEADBEEF);
        chk("wr_wstrb", cap_wstrb, 4'hF);
        chk("wr_count", n_aw * 16 + n_w, 17);

        rdata_cfg = 32'h12345678;
        push(72'h52_00001004, 5);
        exp_reply("rd_ok", 4, 40'h12345678);
        chk("rd_araddr", cap_araddr, 32'h00001004);
        chk("rd_count", n_ar, 1);

        bresp_cfg = 2'b10;
        push(72'h57_00002000_00000001, 9);
        exp_reply("wr_err", 1, 40'h45);
        bresp_cfg = 2'b00;
        rresp_cfg = 2'b11;
        push(72'h52_00002000, 5);
        exp_reply("rd_err", 1, 40'h45);
        rresp_cfg = 2'b00;

        rdata_cfg = 32'hCAFEF00D;
        push(72'h41_52_00000008, 6);
        exp_reply("bad_cmd", 5, 40'h3F_CAFEF00D);
        chk("bad_araddr", cap_araddr, 32'h00000008);

        // partial frame times out; the fetch already issued swallows the next byte (0x00)
        b_aw = n_aw; b_w = n_w; b_ar = n_ar;
        push(72'h57_0000, 3);
        repeat (130) @(negedge clk);
        chk("tmo_busy", busy, 0);
        chk("tmo_nobus", (n_aw - b_aw) + (n_w - b_w) + (n_ar - b_ar), 0);
        chk("tmo_noreply", txq.size(), 0);
        rdata_cfg = 32'h0BADF00D;
        push(72'h00_52_00000010, 6);
        exp_reply("tmo_next", 4, 40'h0BADF00D);
        chk("tmo_araddr", cap_araddr, 32'h00000010);

        aw_dly = 1; w_dly = 3; b_aw = n_aw; b_w = n_w;
        push(72'h57_00000020_11112222, 9);
        exp_reply("wr_split", 1, 40'h4B);
        chk("split_aw", n_aw - b_aw, 1);
        chk("split_w", n_w - b_w, 1);
        chk("split_data", cap_wdata, 32'h11112222);
        aw_dly = 2; w_dly = 2; b_aw = n_aw; b_w = n_w;
        push(72'h57_00000024_33334444, 9);
        exp_reply("wr_same", 1, 40'h4B);
        chk("same_aw", n_aw - b_aw, 1);
        chk("same_w", n_w - b_w, 1);
        chk("same_addr", cap_awaddr, 32'h00000024);
        aw_dly = 0; w_dly = 0;

        uw_en = 0;
        push(72'h52_00000030, 5);
        t = 0;
        while (!u_wvalid && t < 500) begin @(negedge clk); t++; end
        chk("tx_reached", u_wvalid, 1);
        rst = 1;
        @(negedge clk);
        chk("tx_rst_valids", {u_arvalid, u_rready, u_awvalid, u_wvalid, u_bready,
                              m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);
        chk("tx_rst_busy", busy, 0);
        rst = 0; uw_en = 1;
        txq.delete();
        push(72'h57_00000040_55556666, 9);
        exp_reply("after_rst", 1, 40'h4B);
        chk("after_rst_data", cap_wdata, 32'h55556666);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
